bitstream_encoder: RTL and testbench
====================================

// Module: bitstream_encoder
// PURPOSE
//  Serialises one outgoing packet per request onto a single-bit stream for the downstream line stage
//  (bit stuffer / NRZI) and sits in the transmit path of the serial link.
//  DATA0 packets: PID byte + 64 data bits + 16-bit CRC. ACK/NAK packets: PID byte only.
//  The format is bit-exact with what the bitstream decoder accepts: {pid, ~pid}, MSB first.
// PARAMETERS
//  DATA_W  64  payload bits per DATA0 packet
//  CRC_W   16  CRC length appended to DATA0
//  PID_W    4  PID code width; the sent PID byte is 2*PID_W bits
// PORTS
//  clk        in   1       single clock domain, rising edge
//  rst        in   1       reset; asynchronous, active-high
//  send_data  in   1       request DATA0 packet carrying data_in; sampled in IDLE only
//  send_ack   in   1       request ACK handshake packet; sampled in IDLE only
//  send_nak   in   1       request NAK handshake packet; sampled in IDLE only
//  data_in    in   DATA_W  payload; captured in the accept cycle
//  pause      in   1       downstream stall; while high, the current bit is held and not consumed
//  outb       out  1       serial bit, valid while sending=1
//  sending    out  1       high for the whole packet, including pause cycles
//  busy       out  1       high from the accept cycle's next edge until back in IDLE
//  done       out  1       one-cycle pulse after the last bit is consumed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, CRC register all-ones. Reset takes effect immediately, mid-packet too.
//  All outputs are registered.
//  Accept
//   - Request high in IDLE at edge T: first bit is on outb at T+1; sending and busy go 1 at T+1.
//   - Priority for simultaneous requests: send_data > send_nak > send_ack. Losing requests are dropped.
//   - Requests while busy=1 are ignored; there is no queueing.
//  PID codes (shared package): DATA0=4'b1100, ACK=4'b0100, NAK=4'b0101.
//   - Byte on the wire = {pid, ~pid}: DATA0=8'hC3, ACK=8'h4B, NAK=8'h5A.
//  FSM: IDLE -> PID -> (DATA -> CRC, for DATA0) -> DONE -> IDLE.
//   - PID: 8 bits. Then DATA for DATA0, else DONE.
//   - DATA: DATA_W bits, data_in[63] first.
//   - CRC: CRC_W bits, crc[15] first.
//   - DONE: sending=0, busy=0, done=1 for exactly one cycle, then IDLE.
//   - A new request can therefore be accepted no earlier than the cycle after done.
//  Bit counter: 7 bits, counts bits consumed, 0..87.
//   - Advances only on edges with pause=0.
//   - Last bit: count 7 for ACK/NAK, count 87 for DATA0.
//  Pause
//   - Whenever pause=1: outb, counter, CRC register and state all hold.
//   - Packet length on the wire = bits + pause cycles.
//   - pause in IDLE has no effect.
//  CRC
//   - Polynomial x^16+x^15+x^2+1, initial value 16'hFFFF.
//   - Updated once per consumed DATA bit only; the PID is not covered.
//   - Transmitted value: the bitwise complement of the register, MSB first.
//   - Register is reinitialised to all-ones in IDLE.
//  Timing: with no pause, sending stays high for exactly 8 (ACK/NAK) or 88 (DATA0) cycles.
//  The packet is not length-checked against the decoder; the format is fixed by the FSM.
// STRUCTURE
//  Package link_pkg
//   - pid_t enum (DATA0/ACK/NAK)
//   - localparams PKT_BITS_DATA=88, PKT_BITS_HS=8, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF
//   - tx state enum
//  Sub-module crc16_serial (clk, rst, clear, en, inb, crc[15:0])
//   - Same polynomial and init as the receive-side CRC checker.
//  Top level: FSM, PISO shift register (88 bits, loaded at accept with {pid,~pid,data_in,16'h0}), counter.
//   - The CRC field is muxed in from crc16_serial during the CRC state.
// TESTING
//  1 ACK, no pause: send_ack pulse -> outb = 0,1,0,0,1,0,1,1 on 8 consecutive cycles; done pulses at +9.
//  2 NAK and ACK raised together: -> NAK wins; wire carries 8'h5A; exactly 8 sending cycles.
//  3 DATA0, data_in=64'h0123_4567_89AB_CDEF, no pause:
//    -> 88 bits = C3, payload MSB first, ~crc16 as computed by the bench's golden model.
//    -> Bench decoder loopback reports havepkt with matching data and no error.
//  4 Pause: same packet, pause high for 3 cycles at bit 10 and 1 cycle at bit 80
//    -> outb holds during pause; sending high 92 cycles; bits identical to scenario 3.
//  5 Busy lockout: send_nak asserted at bit 30 of a DATA0 packet -> ignored; no second packet after done.
//  6 Reset mid-packet: rst high at bit 40 -> same cycle, outb/sending/busy/done = 0;
//    after release, send_ack -> a clean 8'h4B packet.

Source files
------------

// File: rtl/bitstream_encoder_pkg.sv
// Shared link-layer definitions: PID codes, packet lengths, CRC16 constants and step function.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package link_pkg;

  localparam int DATA_W        = 64;
  localparam int CRC_W         = 16;
  localparam int PID_W         = 4;
  localparam int PKT_BITS_DATA = 88;
  localparam int PKT_BITS_HS   = 8;

  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h8005;
  localparam logic [CRC_W-1:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [PID_W-1:0] {
    PID_DATA0 = 4'b1100,
    PID_ACK   = 4'b0100,
    PID_NAK   = 4'b0101
  } pid_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PID,
    TX_DATA,
    TX_CRC,
    TX_DONE
  } tx_state_t;

  // One serial CRC16 step, MSB-first, x^16+x^15+x^2+1.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic inb);
    logic fb;
    fb = crc[CRC_W-1] ^ inb;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

  // PID byte as sent on the wire: code followed by its complement.
  function automatic logic [2*PID_W-1:0] pid_byte(input pid_t p);
    return {p, ~p};
  endfunction

endpackage

// File: rtl/bitstream_encoder_crc16.sv
// Serial CRC16 accumulator over the consumed payload bits of a DATA0 packet.
// Latency: register reflects a bit one edge after it is presented with en=1.
// Backpressure: none; the caller gates en with the downstream pause.
module crc16_serial
  import link_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             inb,
  output logic [CRC_W-1:0] crc
);

  // Reinitialise when cleared, otherwise fold in one bit per enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, inb);
    end
  end

endmodule

// File: rtl/bitstream_encoder.sv
// Serialises one DATA0/ACK/NAK packet per request onto a single-bit stream, MSB first.
// Latency: first bit on outb the cycle after the accepting edge; done one cycle after the last bit.
// Backpressure: pause=1 holds the current bit, counter, CRC and state; requests ignored unless IDLE.
module bitstream_encoder
  import link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              send_data,
  input  logic              send_ack,
  input  logic              send_nak,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pause,
  output logic              outb,
  output logic              sending,
  output logic              busy,
  output logic              done
);

  localparam int CRC_START = PKT_BITS_DATA - CRC_W;

  tx_state_t                state;
  tx_state_t                state_nxt;
  pid_t                     pid_q;
  pid_t                     pid_sel;
  logic [6:0]               cnt;
  logic [6:0]               cnt_nxt;
  logic [PKT_BITS_DATA-1:0] sreg;
  logic [PKT_BITS_DATA-1:0] sreg_load;
  logic [CRC_W-1:0]         crc_cur;
  logic [CRC_W-1:0]         crc_now;
  logic [3:0]               crc_sel;
  logic                     any_req;
  logic                     in_pkt;
  logic                     last_bit;
  logic                     next_bit;

  // Request arbitration and packet image loaded into the shift register at accept.
  always_comb begin
    any_req = send_data | send_nak | send_ack;
    if (send_data) begin
      pid_sel = PID_DATA0;
    end else if (send_nak) begin
      pid_sel = PID_NAK;
    end else begin
      pid_sel = PID_ACK;
    end
    sreg_load = {pid_byte(pid_sel), data_in, {CRC_W{1'b0}}};
  end

  // Next-bit selection, end-of-packet detection and field sequencing.
  always_comb begin
    in_pkt  = (state == TX_PID) || (state == TX_DATA) || (state == TX_CRC);
    cnt_nxt = cnt + 7'd1;
    // The last payload bit is folded into the CRC on the same edge the first CRC
    // bit is launched, so look one step ahead while still in DATA.
    crc_now = (state == TX_DATA) ? crc16_step(crc_cur, outb) : crc_cur;
    // Wire bit n in the CRC field carries crc[87-n]; 87-n reduced mod 16.
    crc_sel = 4'd7 - cnt_nxt[3:0];
    if (cnt_nxt >= 7'(CRC_START)) begin
      next_bit = ~crc_now[crc_sel];
    end else begin
      next_bit = sreg[PKT_BITS_DATA-2];
    end
    last_bit  = ((state == TX_PID) && (cnt == 7'(PKT_BITS_HS - 1)) && (pid_q != PID_DATA0)) ||
                ((state == TX_CRC) && (cnt == 7'(PKT_BITS_DATA - 1)));
    state_nxt = state;
    if ((state == TX_PID) && (cnt == 7'(PKT_BITS_HS - 1))) begin
      state_nxt = TX_DATA;
    end else if ((state == TX_DATA) && (cnt == 7'(CRC_START - 1))) begin
      state_nxt = TX_CRC;
    end
  end

  // Transmit FSM with registered outputs, shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      pid_q   <= PID_ACK;
      cnt     <= 7'd0;
      sreg    <= '0;
      outb    <= 1'b0;
      sending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          done <= 1'b0;
          cnt  <= 7'd0;
          if (any_req) begin
            pid_q   <= pid_sel;
            sreg    <= sreg_load;
            outb    <= sreg_load[PKT_BITS_DATA-1];
            sending <= 1'b1;
            busy    <= 1'b1;
            state   <= TX_PID;
          end
        end
        TX_PID, TX_DATA, TX_CRC: begin
          if (!pause) begin
            cnt  <= cnt_nxt;
            sreg <= {sreg[PKT_BITS_DATA-2:0], 1'b0};
            if (last_bit) begin
              outb    <= 1'b0;
              sending <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= TX_DONE;
            end else begin
              outb  <= next_bit;
              state <= state_nxt;
            end
          end
        end
        TX_DONE: begin
          done  <= 1'b0;
          cnt   <= 7'd0;
          state <= TX_IDLE;
        end
        default: begin
          state <= TX_IDLE;
        end
      endcase
    end
  end

  crc16_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (state == TX_IDLE),
    .en    ((state == TX_DATA) && !pause),
    .inb   (outb),
    .crc   (crc_cur)
  );

  logic unused_in_pkt;
  assign unused_in_pkt = in_pkt;

endmodule

// File: tb/tb_bitstream_encoder.sv
// Self-checking bench for bitstream_encoder against a packet-level reference model.
// Latency: n/a.
// Backpressure: pause driven per bit index from the bench.
module tb_bitstream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_data;
  logic        send_ack;
  logic        send_nak;
  logic [63:0] data_in;
  logic        pause;
  logic        outb;
  logic        sending;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [87:0] got;
  int          nb;
  int          sc;
  int          dc;
  int          he;

  always #5 clk = ~clk;

  bitstream_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .send_data (send_data),
    .send_ack  (send_ack),
    .send_nak  (send_nak),
    .data_in   (data_in),
    .pause     (pause),
    .outb      (outb),
    .sending   (sending),
    .busy      (busy),
    .done      (done)
  );

  // Reference CRC: polynomial long division, one message bit at a time, MSB first.
  function automatic logic [15:0] ref_crc(input logic [63:0] d);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 63; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h8005;
      else              r = r << 1;
    end
    return r;
  endfunction

  // Expected wire image, left-aligned: bit n of the packet is at [87-n].
  function automatic logic [87:0] ref_packet(input logic [3:0] pid, input logic [63:0] d);
    if (pid == 4'b1100) return {pid, ~pid, d, ~ref_crc(d)};
    return {pid, ~pid, 80'h0};
  endfunction

  // Drives pause/nak at chosen bit indices and records consumed bits until done.
  task automatic run_packet(input int p1b, input int p1l, input int p2b, input int p2l,
                            input int nakb, output logic [87:0] bits, output int nbits,
                            output int scyc, output int done_cyc, output int hold_err);
    int   cyc;
    int   u1;
    int   u2;
    logic held;
    logic held_v;
    cyc = 0; u1 = 0; u2 = 0; held = 1'b0; held_v = 1'b0;
    bits = '0; nbits = 0; scyc = 0; done_cyc = -1; hold_err = 0;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      send_data = 1'b0; send_ack = 1'b0; send_nak = 1'b0; pause = 1'b0;
      if (done) begin
        done_cyc = cyc;
      end else if (sending) begin
        scyc++;
        if (nbits == nakb) send_nak = 1'b1;
        if (nbits == p1b && u1 < p1l) begin
          pause = 1'b1; u1++;
        end else if (nbits == p2b && u2 < p2l) begin
          pause = 1'b1; u2++;
        end
        if (held_v && held !== outb) hold_err++;
        if (pause) begin
          held = outb; held_v = 1'b1;
        end else begin
          held_v = 1'b0;
          if (nbits < 88) bits[87-nbits] = outb;
          nbits++;
        end
      end
    end
    pause = 1'b0; send_nak = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; send_data = 0; send_ack = 0; send_nak = 0; pause = 0; data_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({outb, sending, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=0000", {outb, sending, busy, done});
    end
    rst = 1'b0;
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    checks++;
    if ({outb, sending, busy, done} !== 4'b0) begin
      errors++; $display("FAIL idle_pause got=%b want=0000", {outb, sending, busy, done});
    end
  endtask

  task automatic test_ack();
    @(negedge clk);
    send_ack = 1'b1;
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    checks++;
    if (got[87:80] !== 8'h4B || nb !== 8) begin
      errors++; $display("FAIL ack_bits got=%h n=%0d want=4b n=8", got[87:80], nb);
    end
    checks++;
    if (sc !== 8 || dc !== 9) begin
      errors++; $display("FAIL ack_timing sending=%0d done_at=%0d want 8/9", sc, dc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL ack_done_pulse done=%b want=0", done);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    send_ack = 1'b1; send_nak = 1'b1;
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    checks++;
    if (got[87:80] !== 8'h5A || sc !== 8) begin
      errors++; $display("FAIL prio_nak got=%h sending=%0d want=5a/8", got[87:80], sc);
    end
    @(negedge clk);
    data_in = 64'hFEDC_BA98_7654_3210;
    send_ack = 1'b1; send_nak = 1'b1; send_data = 1'b1;
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    checks++;
    if (got !== ref_packet(4'b1100, 64'hFEDC_BA98_7654_3210) || nb !== 88) begin
      errors++; $display("FAIL prio_data got=%h want=%h", got,
                         ref_packet(4'b1100, 64'hFEDC_BA98_7654_3210));
    end
  endtask

  task automatic test_data_fixed();
    logic [7:0]  pidb;
    logic [63:0] pay;
    logic        havepkt;
    @(negedge clk);
    data_in = 64'h0123_4567_89AB_CDEF;
    send_data = 1'b1;
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    checks++;
    if (got !== ref_packet(4'b1100, 64'h0123_4567_89AB_CDEF)) begin
      errors++; $display("FAIL data_bits got=%h want=%h", got,
                         ref_packet(4'b1100, 64'h0123_4567_89AB_CDEF));
    end
    checks++;
    if (sc !== 88 || dc !== 89) begin
      errors++; $display("FAIL data_timing sending=%0d done_at=%0d want 88/89", sc, dc);
    end
    pidb = got[87:80];
    pay  = got[79:16];
    havepkt = (pidb[7:4] == ~pidb[3:0]) && (pidb[7:4] == 4'hC) && (got[15:0] == ~ref_crc(pay));
    checks++;
    if (havepkt !== 1'b1 || pay !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL loopback havepkt=%b data=%h want 1/0123456789abcdef", havepkt, pay);
    end
  endtask

  task automatic test_pause();
    @(negedge clk);
    data_in = 64'h0123_4567_89AB_CDEF;
    send_data = 1'b1;
    run_packet(10, 3, 80, 1, -1, got, nb, sc, dc, he);
    checks++;
    if (got !== ref_packet(4'b1100, 64'h0123_4567_89AB_CDEF)) begin
      errors++; $display("FAIL pause_bits got=%h want=%h", got,
                         ref_packet(4'b1100, 64'h0123_4567_89AB_CDEF));
    end
    checks++;
    if (sc !== 92 || dc !== 93 || he !== 0) begin
      errors++; $display("FAIL pause_timing sending=%0d done_at=%0d holderr=%0d want 92/93/0",
                         sc, dc, he);
    end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [3:0]  pid;
    int          k, len, p1b, p1l, p2b, p2l, exp_sc;
    for (int it = 0; it < 8; it++) begin
      d = {$urandom, $urandom};
      k = $urandom_range(0, 2);
      pid = (k == 0) ? 4'b1100 : (k == 1) ? 4'b0100 : 4'b0101;
      len = (k == 0) ? 88 : 8;
      p1b = $urandom_range(0, 87); p1l = $urandom_range(0, 4);
      p2b = $urandom_range(0, 87); p2l = $urandom_range(0, 4);
      if (k != 0) begin
        p1b = $urandom_range(0, 7);
      end
      exp_sc = len + ((p1b < len) ? p1l : 0) + ((p2b < len) ? p2l : 0);
      @(negedge clk);
      data_in = d;
      send_data = (k == 0); send_ack = (k == 1); send_nak = (k == 2);
      run_packet(p1b, p1l, p2b, p2l, -1, got, nb, sc, dc, he);
      checks++;
      if (got !== ref_packet(pid, d) || nb !== len) begin
        errors++; $display("FAIL rand_bits it=%0d got=%h n=%0d want=%h n=%0d",
                           it, got, nb, ref_packet(pid, d), len);
      end
      checks++;
      if (sc !== exp_sc || dc !== exp_sc + 1 || he !== 0) begin
        errors++; $display("FAIL rand_timing it=%0d sending=%0d done_at=%0d holderr=%0d want %0d/%0d/0",
                           it, sc, dc, he, exp_sc, exp_sc + 1);
      end
    end
  endtask

  task automatic test_busy_lockout();
    int extra;
    @(negedge clk);
    data_in = 64'hA5A5_0F0F_3C3C_9696;
    send_data = 1'b1;
    run_packet(-1, 0, -1, 0, 30, got, nb, sc, dc, he);
    checks++;
    if (got !== ref_packet(4'b1100, 64'hA5A5_0F0F_3C3C_9696) || sc !== 88) begin
      errors++; $display("FAIL lockout_bits got=%h sending=%0d want=%h/88", got, sc,
                         ref_packet(4'b1100, 64'hA5A5_0F0F_3C3C_9696));
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (sending || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL lockout_second got=%0d active cycles want=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    send_ack = 1'b1;
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    send_nak = 1'b1;
    @(negedge clk);
    checks++;
    if (sending !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done_ignored sending=%b busy=%b want 0/0", sending, busy);
    end
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    checks++;
    if (got[87:80] !== 8'h5A || dc !== 9) begin
      errors++; $display("FAIL b2b_second got=%h done_at=%0d want=5a/9", got[87:80], dc);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_in = {$urandom, $urandom};
    send_data = 1'b1;
    repeat (41) begin
      @(negedge clk);
      send_data = 1'b0;
    end
    checks++;
    if (sending !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_active sending=%b busy=%b want 1/1", sending, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({outb, sending, busy, done} !== 4'b0) begin
      errors++; $display("FAIL mid_reset got=%b want=0000", {outb, sending, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_ack = 1'b1;
    run_packet(-1, 0, -1, 0, -1, got, nb, sc, dc, he);
    checks++;
    if (got[87:80] !== 8'h4B || sc !== 8 || dc !== 9) begin
      errors++; $display("FAIL post_reset_ack got=%h sending=%0d done_at=%0d want 4b/8/9",
                         got[87:80], sc, dc);
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_priority();
    test_data_fixed();
    test_pause();
    test_random();
    test_busy_lockout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
